// File: rtl/edge_event_arbiter.sv
// Per-channel rising/falling edge detector feeding a round-robin scheduler
// that shares one registered valid/ready event port among all channels.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] data,
  input  logic [NUM_CH-1:0] rise_en,
  input  logic [NUM_CH-1:0] fall_en,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [ID_W-1:0]   event_id,
  output logic              event_rising,
  output logic [NUM_CH-1:0] overflow,
  input  logic              overflow_clr
);

  logic [NUM_CH-1:0] data_q;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] pend_pol;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] pol_nxt;
  logic [NUM_CH-1:0] ovf_set;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic              slot_free;
  logic              do_grant;

  assign rise      = data & ~data_q & rise_en;
  assign fall      = ~data & data_q & fall_en;
  assign slot_free = ~event_valid | event_ready;
  assign do_grant  = slot_free & gnt_found;

  // First pending channel searching upward from last_grant+1, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ID_W'((int'(last_grant) + 1 + k) % NUM_CH);
      if (!gnt_found && pending[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // A channel granted this cycle frees its entry, so a coincident edge is kept.
  always_comb begin
    logic granted;
    pend_nxt = pending;
    pol_nxt  = pend_pol;
    ovf_set  = '0;
    granted  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      granted = do_grant && (gnt_idx == ID_W'(i));
      if (rise[i] || fall[i]) begin
        if (!pending[i] || granted) begin
          pend_nxt[i] = 1'b1;
          pol_nxt[i]  = rise[i];
        end else begin
          ovf_set[i] = 1'b1;
        end
      end else if (granted) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q       <= data;
      pending      <= '0;
      pend_pol     <= '0;
      last_grant   <= ID_W'(NUM_CH - 1);
      event_valid  <= 1'b0;
      event_id     <= '0;
      event_rising <= 1'b0;
      overflow     <= '0;
    end else begin
      data_q   <= data;
      pending  <= pend_nxt;
      pend_pol <= pol_nxt;
      overflow <= ovf_set | (overflow_clr ? '0 : overflow);
      if (slot_free) begin
        event_valid <= do_grant;
        if (do_grant) begin
          event_id     <= gnt_idx;
          event_rising <= pend_pol[gnt_idx];
          last_grant   <= gnt_idx;
        end
      end
    end
  end

endmodule
